serial_word_loader: RTL

SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

---
 rtl/serial_word_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_word_loader.sv
// serial_word_loader: assembles LSB-first serial bits into a WIDTH-bit word and
// holds it with LOAD asserted until the downstream register bank acknowledges.
// Optional even-parity check on an extra trailing bit: define
// SERIAL_WORD_LOADER_PARITY_EN to compile it in (PERR is tied to 0 otherwise).
module serial_word_loader #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             SVALID,
    output logic             SREADY,
    output logic [WIDTH-1:0] DOUT,
    output logic             LOAD,
    input  logic             ACK,
    output logic             BUSY,
    output logic             PERR
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef SERIAL_WORD_LOADER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        HOLD  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd3
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             sready_q, sready_d;
    logic             perr_q, perr_d;
    logic             xfer;

    assign xfer = SVALID & sready_q;

    // State, counter, assembly and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            dout_q   <= '0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            sready_q <= 1'b1;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            dout_q   <= dout_d;
            load_q   <= load_d;
            busy_q   <= busy_d;
            sready_q <= sready_d;
            perr_q   <= perr_d;
        end
    end

    // Next-state, bit placement and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        perr_d  = 1'b0;

        // Bit k of the word goes to position k; decoded to keep index widths exact
        if (xfer && (state_q == IDLE || state_q == SHIFT)) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (cnt_q == CW'(i)) sh_d[i] = SIN;
            end
        end

        case (state_q)
            IDLE, SHIFT: begin
                if (xfer) begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d = '0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
                        state_d = PAR;
`else
                        state_d = HOLD;
                        dout_d  = sh_d;
`endif
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = SHIFT;
                    end
                end
            end
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            PAR: begin
                if (xfer) begin
                    if ((^sh_q ^ SIN) == 1'b0) begin
                        state_d = HOLD;
                        dout_d  = sh_q;
                    end else begin
                        state_d = IDLE;
                        perr_d  = 1'b1;
                    end
                end
            end
`endif
            HOLD: begin
                if (ACK) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        load_d   = (state_d == HOLD);
        busy_d   = (state_d != IDLE);
        sready_d = (state_d != HOLD);
    end

    assign SREADY = sready_q;
    assign DOUT   = dout_q;
    assign LOAD   = load_q;
    assign BUSY   = busy_q;
    assign PERR   = perr_q;

endmodule
